// File: rtl/dram_pkt_writer.sv
// dram_pkt_writer
//   Drains complete 128-word packets from the RX buffer read port, packs four
//   16-bit words per 64-bit beat (word 0 in bits [15:0]) and writes each packet
//   as one BURST_LEN-beat Avalon-MM burst into a circular DRAM region of
//   RING_PKTS packets starting at beat address BASE_ADDR.
//   Optional feature macro: DRAM_PKT_CHECK_EN enables header/trailer checking
//   (pkt_err / err_count); without it both outputs are constant 0.
// Ports:
//   DRAM_RD_clk, rst_n        clock, synchronous active-low reset
//   wr_enable                 allow new packets (sampled in IDLE only)
//   Buffer_Data_Ready         buffer holds at least one full packet
//   RX_Buffer_empty           buffer empty; reads are withheld while high
//   DRAM_RD_req               buffer read strobe, data valid one cycle later
//   Buffer_RD_Data            buffer read data
//   avm_*                     Avalon-MM write master (beat addresses)
//   pkt_count                 packets fully written
//   wr_busy                   high outside IDLE
//   pkt_err, err_count        malformed-packet pulse / saturating count
module dram_pkt_writer #(
    parameter int unsigned       ADDR_W    = 26,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       RING_PKTS = 1024,
    parameter int unsigned       BURST_LEN = 32
) (
    input  logic              DRAM_RD_clk,
    input  logic              rst_n,
    input  logic              wr_enable,
    input  logic              Buffer_Data_Ready,
    input  logic              RX_Buffer_empty,
    output logic              DRAM_RD_req,
    input  logic [15:0]       Buffer_RD_Data,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [63:0]       avm_writedata,
    output logic [5:0]        avm_burstcount,
    input  logic              avm_waitrequest,
    output logic [31:0]       pkt_count,
    output logic              wr_busy,
    output logic              pkt_err,
    output logic [15:0]       err_count
);

    localparam int unsigned    BW        = $clog2(BURST_LEN);
    localparam int unsigned    AW1       = ADDR_W + 1;
    localparam logic [AW1-1:0] RING_END  = AW1'(BASE_ADDR) + AW1'(RING_PKTS * BURST_LEN);
    localparam logic [BW-1:0]  LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [5:0]     BURST_CNT = 6'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [BW-1:0]     beat_idx;
    logic [2:0]        issued;     // reads issued for the current beat (0..4)
    logic [1:0]        lane;       // next lane to capture
    logic              rd_pend;    // a read was issued last cycle; data valid now
    logic [AW1-1:0]    base_step;
    logic              accept;

    // Combinational so the strobe can never coincide with RX_Buffer_empty.
    assign DRAM_RD_req = (state == RD) && (issued < 3'd4) && !RX_Buffer_empty;
    assign accept      = avm_write && !avm_waitrequest;
    assign base_step   = AW1'(base) + AW1'(BURST_LEN);

`ifdef DRAM_PKT_CHECK_EN
    logic pkt_bad;
    logic word_bad;

    // Only word 0 (header) and word 127 (trailer) are inspected.
    always_comb begin
        word_bad = 1'b0;
        if (beat_idx == '0 && lane == 2'd0)
            word_bad = (Buffer_RD_Data != 16'hDEAD) && (Buffer_RD_Data != 16'hBEEF);
        else if (beat_idx == LAST_BEAT && lane == 2'd3)
            word_bad = (Buffer_RD_Data != 16'h7FFF);
    end
`else
    assign pkt_err   = 1'b0;
    assign err_count = '0;
`endif

    always_ff @(posedge DRAM_RD_clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            base           <= BASE_ADDR;
            beat_idx       <= '0;
            issued         <= '0;
            lane           <= '0;
            rd_pend        <= 1'b0;
            avm_address    <= '0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            avm_burstcount <= '0;
            pkt_count      <= '0;
            wr_busy        <= 1'b0;
`ifdef DRAM_PKT_CHECK_EN
            pkt_bad        <= 1'b0;
            pkt_err        <= 1'b0;
            err_count      <= '0;
`endif
        end else begin
            rd_pend <= DRAM_RD_req;
`ifdef DRAM_PKT_CHECK_EN
            pkt_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (wr_enable && Buffer_Data_Ready) begin
                        state    <= RD;
                        wr_busy  <= 1'b1;
                        beat_idx <= '0;
                        issued   <= '0;
                        lane     <= '0;
`ifdef DRAM_PKT_CHECK_EN
                        pkt_bad  <= 1'b0;
`endif
                    end
                end
                RD: begin
                    if (DRAM_RD_req)
                        issued <= issued + 3'd1;
                    // Lanes are filled straight into the write-data register;
                    // avm_write is low here, so the bus never sees partial beats.
                    if (rd_pend) begin
                        avm_writedata[{lane, 4'b0000} +: 16] <= Buffer_RD_Data;
                        lane <= lane + 2'd1;
`ifdef DRAM_PKT_CHECK_EN
                        if (word_bad)
                            pkt_bad <= 1'b1;
`endif
                        if (lane == 2'd3) begin
                            state          <= WR;
                            avm_write      <= 1'b1;
                            avm_address    <= base + ADDR_W'(beat_idx);
                            avm_burstcount <= BURST_CNT;
                        end
                    end
                end
                WR: begin
                    if (accept) begin
                        avm_write      <= 1'b0;
                        avm_burstcount <= '0;
                        issued         <= '0;
                        if (beat_idx == LAST_BEAT) begin
                            state <= DONE;
`ifdef DRAM_PKT_CHECK_EN
                            pkt_err <= pkt_bad;
                            if (pkt_bad && err_count != '1)
                                err_count <= err_count + 16'd1;
`endif
                        end else begin
                            beat_idx <= beat_idx + BW'(1);
                            state    <= RD;
                        end
                    end
                end
                DONE: begin
                    pkt_count <= pkt_count + 32'd1;
                    base      <= (base_step >= RING_END) ? BASE_ADDR : base_step[ADDR_W-1:0];
                    wr_busy   <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_pkt_writer.sv
`timescale 1ns/1ps
module tb_dram_pkt_writer;

    localparam int unsigned ADDR_W = 26;
    localparam int unsigned RING   = 2;
    localparam int unsigned BL     = 32;

`ifdef DRAM_PKT_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_enable;
    logic              Buffer_Data_Ready;
    logic              RX_Buffer_empty;
    logic              DRAM_RD_req;
    logic [15:0]       Buffer_RD_Data;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_write;
    logic [63:0]       avm_writedata;
    logic [5:0]        avm_burstcount;
    logic              avm_waitrequest;
    logic [31:0]       pkt_count;
    logic              wr_busy;
    logic              pkt_err;
    logic [15:0]       err_count;

    always #5 clk = ~clk;

    dram_pkt_writer #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(26'h0),
        .RING_PKTS(RING),
        .BURST_LEN(BL)
    ) dut (
        .DRAM_RD_clk      (clk),
        .rst_n            (rst_n),
        .wr_enable        (wr_enable),
        .Buffer_Data_Ready(Buffer_Data_Ready),
        .RX_Buffer_empty  (RX_Buffer_empty),
        .DRAM_RD_req      (DRAM_RD_req),
        .Buffer_RD_Data   (Buffer_RD_Data),
        .avm_address      (avm_address),
        .avm_write        (avm_write),
        .avm_writedata    (avm_writedata),
        .avm_burstcount   (avm_burstcount),
        .avm_waitrequest  (avm_waitrequest),
        .pkt_count        (pkt_count),
        .wr_busy          (wr_busy),
        .pkt_err          (pkt_err),
        .err_count        (err_count)
    );

    // Reference model state: buffer contents and expected DRAM beats.
    logic [15:0]       buf_q[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [63:0]       exp_data[$];
    int unsigned       pkt_idx;
    int unsigned       exp_errs;
    int unsigned       err_pulses;
    int unsigned       beats_acc;
    int unsigned       popped;

    // Stimulus controls consumed by the bus-model process.
    bit          force_ready;
    bit          empty_arm;
    int unsigned empty_at;
    int unsigned empty_stall;
    bit          wait_arm;
    int unsigned wait_beat;
    int unsigned ws_cnt;
    bit          rand_wait;
    bit          rand_empty;

    logic [15:0]       hold;
    bit                have_hold;
    bit                stalled;
    logic [ADDR_W-1:0] st_addr;
    logic [63:0]       st_data;

    int n_checks;
    int n_errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    function automatic logic [63:0] exp_err_count();
        if (!CHK_EN)
            return 64'd0;
        return (exp_errs > 65535) ? 64'd65535 : 64'(exp_errs);
    endfunction

    task automatic push_packet(input logic [15:0] hdr, input logic [15:0] ts,
                               input logic [15:0] trl, input bit cnt_data);
        logic [15:0] w [128];
        w[0] = hdr;
        w[1] = ts;
        for (int i = 2; i < 127; i++)
            w[i] = cnt_data ? 16'(i - 2) : 16'($urandom);
        w[127] = trl;
        for (int i = 0; i < 128; i++)
            buf_q.push_back(w[i]);
        for (int b = 0; b < int'(BL); b++) begin
            exp_addr.push_back(ADDR_W'((pkt_idx % RING) * BL + 32'(b)));
            exp_data.push_back({w[4*b+3], w[4*b+2], w[4*b+1], w[4*b]});
        end
        if (!((hdr == 16'hDEAD || hdr == 16'hBEEF) && trl == 16'h7FFF))
            exp_errs++;
        pkt_idx++;
    endtask

    task automatic run_until_count(input string tag, input logic [31:0] target,
                                   output int unsigned lat);
        int unsigned n;
        n   = 0;
        lat = 0;
        while (!wr_busy && n < 50) begin
            step();
            n++;
        end
        if (!wr_busy) begin
            check({tag, "_start_timeout"}, 64'(wr_busy), 64'd1);
            return;
        end
        while (pkt_count != target && lat < 3000) begin
            step();
            lat++;
        end
        if (pkt_count != target)
            check({tag, "_done_timeout"}, 64'(pkt_count), 64'(target));
    endtask

    // Buffer read port and Avalon slave model, plus per-cycle protocol checks.
    initial begin
        forever begin
            @(negedge clk);
            if (have_hold) begin
                Buffer_RD_Data = hold;
                have_hold      = 1'b0;
            end
            if (empty_stall > 0)
                empty_stall--;
            if (empty_arm && popped >= empty_at) begin
                empty_arm   = 1'b0;
                empty_stall = 6;
            end
            RX_Buffer_empty   = (buf_q.size() == 0) || (empty_stall > 0) ||
                                (rand_empty && $urandom_range(0, 3) == 0);
            Buffer_Data_Ready = force_ready || (buf_q.size() >= 128);
            if (ws_cnt > 0)
                ws_cnt--;
            avm_waitrequest = (ws_cnt > 0) || (rand_wait && $urandom_range(0, 2) == 0);
            #1;
            if (RX_Buffer_empty)
                check("req_while_empty", 64'(DRAM_RD_req), 64'd0);
            if (avm_write)
                check("req_during_write", 64'(DRAM_RD_req), 64'd0);
            if (DRAM_RD_req) begin
                if (buf_q.size() == 0) begin
                    check("read_underflow", 64'd1, 64'd0);
                end else begin
                    hold      = buf_q.pop_front();
                    have_hold = 1'b1;
                    popped++;
                end
            end
            if (wait_arm && avm_write && (beats_acc % BL) == wait_beat) begin
                wait_arm        = 1'b0;
                ws_cnt          = 10;
                avm_waitrequest = 1'b1;
            end
            if (stalled) begin
                check("stall_write_held", 64'(avm_write), 64'd1);
                check("stall_addr", 64'(avm_address), 64'(st_addr));
                check("stall_data", avm_writedata, st_data);
            end
            stalled = avm_write && avm_waitrequest;
            st_addr = avm_address;
            st_data = avm_writedata;
            if (avm_write && !avm_waitrequest) begin
                check("burstcount", 64'(avm_burstcount), 64'(BL));
                if (exp_addr.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    check("beat_addr", 64'(avm_address), 64'(exp_addr.pop_front()));
                    check("beat_data", avm_writedata, exp_data.pop_front());
                end
                beats_acc++;
            end
            if (pkt_err)
                err_pulses++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned lat;
        int unsigned n;
        logic [15:0] hdr;
        logic [15:0] trl;

        n_checks          = 0;
        n_errors          = 0;
        rst_n             = 1'b0;
        wr_enable         = 1'b0;
        force_ready       = 1'b1;
        Buffer_Data_Ready = 1'b1;
        RX_Buffer_empty   = 1'b1;
        Buffer_RD_Data    = '0;
        avm_waitrequest   = 1'b0;

        // Reset with Ready forced high.
        repeat (2) step();
        check("rst_req", 64'(DRAM_RD_req), 64'd0);
        check("rst_write", 64'(avm_write), 64'd0);
        check("rst_addr", 64'(avm_address), 64'd0);
        check("rst_data", avm_writedata, 64'd0);
        check("rst_burst", 64'(avm_burstcount), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        check("rst_busy", 64'(wr_busy), 64'd0);
        check("rst_pkt_err", 64'(pkt_err), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        rst_n = 1'b1;
        repeat (5) step();
        check("idle_no_enable_busy", 64'(wr_busy), 64'd0);
        check("idle_no_enable_count", 64'(pkt_count), 64'd0);
        force_ready = 1'b0;

        // Single packet, counter payload, no stalls.
        wr_enable = 1'b1;
        push_packet(16'hDEAD, 16'h0005, 16'h7FFF, 1'b1);
        run_until_count("t2", 32'd1, lat);
        check("t2_latency", 64'(lat), 64'd193);
        step();
        check("t2_busy_after", 64'(wr_busy), 64'd0);
        check("t2_beats_left", 64'(exp_addr.size()), 64'd0);

        // Ten-cycle waitrequest on beat 7.
        wait_arm  = 1'b1;
        wait_beat = 7;
        push_packet(16'hBEEF, 16'($urandom), 16'h7FFF, 1'b0);
        run_until_count("t3", 32'd2, lat);
        check("t3_latency", 64'(lat), 64'd203);
        check("t3_wait_fired", 64'(wait_arm), 64'd0);
        check("t3_beats_left", 64'(exp_addr.size()), 64'd0);

        // Buffer reports empty for six cycles in the middle of beat 10.
        empty_arm = 1'b1;
        empty_at  = popped + 42;
        push_packet(16'hDEAD, 16'($urandom), 16'h7FFF, 1'b0);
        run_until_count("t4", 32'd3, lat);
        check("t4_empty_fired", 64'(empty_arm), 64'd0);
        check("t4_beats_left", 64'(exp_addr.size()), 64'd0);
        check("t4_err_count", 64'(err_count), exp_err_count());

        // Reset, then three back-to-back packets through a two-packet ring.
        rst_n = 1'b0;
        repeat (2) step();
        pkt_idx    = 0;
        exp_errs   = 0;
        err_pulses = 0;
        beats_acc  = 0;
        rst_n      = 1'b1;
        step();
        check("t5_rst_pkt_count", 64'(pkt_count), 64'd0);
        for (int p = 0; p < 3; p++)
            push_packet(16'hBEEF, 16'($urandom), 16'h7FFF, 1'b0);
        run_until_count("t5", 32'd3, lat);
        check("t5_latency", 64'(lat), 64'd581);
        check("t5_pkt_count", 64'(pkt_count), 64'd3);
        check("t5_beats_left", 64'(exp_addr.size()), 64'd0);

        // Malformed trailer, then a good packet, then a malformed header.
        push_packet(16'hDEAD, 16'($urandom), 16'h7FFE, 1'b0);
        run_until_count("t6a", 32'd4, lat);
        step();
        check("t6a_err_count", 64'(err_count), exp_err_count());
        check("t6a_err_pulses", 64'(err_pulses), CHK_EN ? 64'd1 : 64'd0);
        push_packet(16'hBEEF, 16'($urandom), 16'h7FFF, 1'b0);
        run_until_count("t6b", 32'd5, lat);
        step();
        check("t6b_err_count", 64'(err_count), exp_err_count());
        check("t6b_beats_left", 64'(exp_addr.size()), 64'd0);
        push_packet(16'h1234, 16'($urandom), 16'h7FFF, 1'b0);
        run_until_count("t6c", 32'd6, lat);
        step();
        check("t6c_err_count", 64'(err_count), exp_err_count());
        check("t6c_err_pulses", 64'(err_pulses), 64'(CHK_EN ? exp_errs : 0));

        // Randomised traffic: random stalls, empties, wr_enable toggling, headers.
        rand_wait  = 1'b1;
        rand_empty = 1'b1;
        for (int p = 0; p < 4; p++) begin
            case ($urandom_range(0, 2))
                0:       hdr = 16'hDEAD;
                1:       hdr = 16'hBEEF;
                default: hdr = 16'($urandom);
            endcase
            trl = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h7FFF;
            push_packet(hdr, 16'($urandom), trl, 1'b0);
        end
        n = 0;
        while (pkt_count != 32'd10 && n < 20000) begin
            step();
            wr_enable = ($urandom_range(0, 3) != 0);
            n++;
        end
        wr_enable = 1'b1;
        check("rand_pkt_count", 64'(pkt_count), 64'd10);
        rand_wait  = 1'b0;
        rand_empty = 1'b0;
        repeat (3) step();
        check("rand_beats_left", 64'(exp_addr.size()), 64'd0);
        check("rand_buf_left", 64'(buf_q.size()), 64'd0);
        check("rand_err_count", 64'(err_count), exp_err_count());
        check("rand_err_pulses", 64'(err_pulses), 64'(CHK_EN ? exp_errs : 0));
        check("rand_busy", 64'(wr_busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
